// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver.
// Synchronizes and deglitches the raw KBCLK/KBDAT pins, deserializes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) and reports
// each frame as a good byte, a parity fault or a framing/timeout fault.
module ps2_rx_frame #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbclk,
  input  logic       kbdat,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Input synchronizers; the bus idles high, so they reset to 1.
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_s;
  logic                   dat_s;

  // Deglitch filter and edge strobe.
  logic           filt_q;
  logic [FCW-1:0] flt_cnt_q;
  logic           fall_stb_q;

  // Frame FSM and datapath.
  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [7:0]     rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           parity_err_q, parity_err_d;
  logic           frame_err_q, frame_err_d;
  logic           busy_q, busy_d;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Shift the raw pins through the synchronizer chains.
  // NOTE: every flop is written with <= so all stages update from the
  // values before the edge; blocking assignments would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], kbclk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], kbdat};
    end
  end

  // Flip the filtered clock after FILTER_LEN consecutive differing samples;
  // a 1->0 flip raises fall_stb for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b1;
      flt_cnt_q  <= '0;
      fall_stb_q <= 1'b0;
    end else begin
      fall_stb_q <= 1'b0;
      if (clk_s != filt_q) begin
        if (flt_cnt_q == FCW'(FILTER_LEN - 1)) begin
          filt_q     <= clk_s;
          flt_cnt_q  <= '0;
          fall_stb_q <= ~clk_s;
        end else begin
          flt_cnt_q <= flt_cnt_q + FCW'(1);
        end
      end else begin
        flt_cnt_q <= '0;
      end
    end
  end

  // Next-state logic: deserialize on fall_stb, abort on timeout otherwise.
  // NOTE: every signal gets its hold/default value first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    tmo_d        = (state_q == IDLE || fall_stb_q) ? '0 : tmo_q + TCW'(1);

    if (fall_stb_q) begin
      unique case (state_q)
        IDLE: begin
          // A high data bit here is a stray edge and is ignored.
          if (!dat_s) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {dat_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_s) begin
            frame_err_d = 1'b1;
          end else if (!(^{shift_q, par_q})) begin
            parity_err_d = 1'b1;
          end else begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      shift_d     = '0;
      bit_cnt_d   = 3'd0;
    end

    busy_d = (state_d != IDLE);
  end

  // Register FSM state, datapath and output strobes.
  // NOTE: only control and datapath flops live here, so all of them take
  // the asynchronous reset; there is no storage array to leave unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      tmo_q        <= '0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_q        <= tmo_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
